// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   Host-side PS/2 keyboard receiver. Synchronises and de-glitches the raw
//   PS/2 lines, deserialises 11-bit frames (start, 8 data LSB first, odd
//   parity, stop), folds E0/F0 prefixes into flags, collapses the 8-byte E1
//   Pause sequence into a single event and emits one strobe per key event.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   ps2_clk      raw PS/2 clock (asynchronous)
//   ps2_dat      raw PS/2 data (asynchronous)
//   code         scancode of the last event, held until the next event
//   extended     event was preceded by E0, held with code
//   released     event was preceded by F0, held with code
//   valid        one-cycle strobe: code/extended/released are new
//   parity_err   one-cycle strobe: frame dropped (bad parity or stop bit)
//   timeout_err  one-cycle strobe: partial frame aborted after TIMEOUT clks
module ps2_scancode_rx #(
   parameter int FILTER_LEN = 4,      // 2..8 equal samples to move filtered clock
   parameter int TIMEOUT    = 50000   // clks without a sample before abort
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] code,
   output logic       extended,
   output logic       released,
   output logic       valid,
   output logic       parity_err,
   output logic       timeout_err
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t                state, state_next;
   logic [1:0]            clk_sync, dat_sync;
   logic [FILTER_LEN-1:0] clk_hist;
   logic                  clk_filt, clk_filt_d;
   logic                  sample;
   logic                  sdat;
   logic [2:0]            bit_cnt;
   logic [7:0]            shreg;
   logic                  par_bit;
   logic [15:0]           tcnt;
   logic                  timeout_hit;
   logic                  frame_good;
   logic                  ext_pend, rel_pend;
   logic [2:0]            skip_cnt;

   // decode controls from the output process
   logic emit, emit_e1, set_ext, set_rel, clr_flags, load_skip, dec_skip, perr, terr;

   // ---------------------------------------------------------------- input path
   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         dat_sync   <= 2'b11;
         clk_hist   <= '1;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk};
         dat_sync   <= {dat_sync[0], ps2_dat};
         clk_hist   <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
         // hysteresis: move only when the whole history agrees
         if (&clk_hist)       clk_filt <= 1'b1;
         else if (~|clk_hist) clk_filt <= 1'b0;
         clk_filt_d <= clk_filt;
      end
   end

   assign sample = clk_filt_d & ~clk_filt;   // filtered falling edge
   assign sdat   = dat_sync[1];

   // odd parity over data+parity, and the stop bit is the bit being sampled now
   assign frame_good  = sdat & (^shreg ^ par_bit);
   assign timeout_hit = (state != IDLE) && (tcnt >= TIMEOUT_CNT);

   // ------------------------------------------------------------ state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // ---------------------------------------------------------------- next state
   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      if (timeout_hit) begin
         state_next = IDLE;
      end else if (sample) begin
         case (state)
            IDLE:    if (!sdat) state_next = DATA;
            DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------- output decode
   always_comb begin
      emit      = 1'b0;
      emit_e1   = 1'b0;
      set_ext   = 1'b0;
      set_rel   = 1'b0;
      clr_flags = 1'b0;
      load_skip = 1'b0;
      dec_skip  = 1'b0;
      perr      = 1'b0;
      terr      = 1'b0;
      if (timeout_hit) begin
         terr      = 1'b1;
         clr_flags = 1'b1;
      end else if (sample && state == STOP) begin
         if (!frame_good) begin
            perr      = 1'b1;
            clr_flags = 1'b1;
         end else if (skip_cnt != 3'd0) begin
            dec_skip = 1'b1;            // swallowing the tail of E1 Pause
         end else if (shreg == 8'hE0) begin
            set_ext = 1'b1;
         end else if (shreg == 8'hF0) begin
            set_rel = 1'b1;
         end else if (shreg == 8'hE1) begin
            emit      = 1'b1;
            emit_e1   = 1'b1;
            load_skip = 1'b1;
            clr_flags = 1'b1;
         end else begin
            emit      = 1'b1;
            clr_flags = 1'b1;
         end
      end
   end

   // ------------------------------------------------------- datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt     <= 3'd0;
         shreg       <= 8'h00;
         par_bit     <= 1'b0;
         tcnt        <= 16'd0;
         ext_pend    <= 1'b0;
         rel_pend    <= 1'b0;
         skip_cnt    <= 3'd0;
         code        <= 8'h00;
         extended    <= 1'b0;
         released    <= 1'b0;
         valid       <= 1'b0;
         parity_err  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         valid       <= emit;
         parity_err  <= perr;
         timeout_err <= terr;

         if (emit) begin
            code     <= shreg;
            extended <= emit_e1 ? 1'b0 : ext_pend;
            released <= emit_e1 ? 1'b0 : rel_pend;
         end

         if (clr_flags) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
         end else begin
            if (set_ext) ext_pend <= 1'b1;
            if (set_rel) rel_pend <= 1'b1;
         end

         if (load_skip)     skip_cnt <= 3'd7;
         else if (dec_skip) skip_cnt <= skip_cnt - 3'd1;

         // saturating watchdog, idle while no frame is in progress
         if (sample || state == IDLE) tcnt <= 16'd0;
         else if (tcnt != 16'hFFFF)   tcnt <= tcnt + 16'd1;

         if (sample && !timeout_hit) begin
            case (state)
               IDLE:   bit_cnt <= 3'd0;
               DATA: begin
                  shreg   <= {sdat, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY: par_bit <= sdat;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx
//   Directed and randomized PS/2 frames against a byte-level reference model
//   of the prefix/Pause folding rules. Events seen on the DUT are queued by a
//   monitor and compared with the model queue after each step.
module tb_ps2_scancode_rx;

   localparam int FL   = 4;
   localparam int TO   = 300;
   localparam int HALF = 20;          // ps2_clk half period in clk cycles
   localparam int GAP  = 40;          // idle cycles between frames
   // raw fall -> valid: 2 synchroniser flops, FL history flops,
   // the filtered-clock flop, then the registered outputs
   localparam int LAT  = FL + 4;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset, ps2_clk, ps2_dat;
   logic [7:0] code;
   logic       extended, released, valid, parity_err, timeout_err;

   always #5 clk = ~clk;

   ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_dat     (ps2_dat),
      .code        (code),
      .extended    (extended),
      .released    (released),
      .valid       (valid),
      .parity_err  (parity_err),
      .timeout_err (timeout_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   ev_t obs_q[$];
   int  obs_cyc[$];
   int  pe_cnt = 0, to_cnt = 0, to_cyc = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (valid | parity_err | timeout_err)
            check("strobe_onehot", 32'(valid) + 32'(parity_err) + 32'(timeout_err), 32'd1);
         if (valid) begin
            obs_q.push_back({code, extended, released});
            obs_cyc.push_back(cyc);
         end
         if (parity_err) pe_cnt++;
         if (timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
         end
      end
   end

   // ------------------------------------------------------- reference model
   ev_t exp_q[$];
   bit  m_ext = 1'b0, m_rel = 1'b0;
   int  m_skip = 0;
   int  exp_pe = 0, exp_to = 0;

   task automatic model_good(input logic [7:0] b);
      if (m_skip > 0) m_skip--;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else if (b == 8'hE1) begin
         exp_q.push_back({8'hE1, 1'b0, 1'b0});
         m_skip = 7;
         m_ext  = 1'b0;
         m_rel  = 1'b0;
      end else begin
         exp_q.push_back({b, m_ext, m_rel});
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   // ---------------------------------------------------------------- drivers
   int last_fall = 0;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one bit: data changes while the clock is high, then a full low phase;
   // optionally a 2-cycle low glitch in the middle of the high phase
   task automatic send_bit(input logic b, input bit glitch);
      ps2_dat = b;
      if (glitch) begin
         wait_cyc(6);
         ps2_clk = 1'b0;
         wait_cyc(2);
         ps2_clk = 1'b1;
         wait_cyc(HALF - 8);
      end else begin
         wait_cyc(HALF);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit glitch);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
      ps2_dat = 1'b1;
      wait_cyc(GAP);
   endtask

   task automatic tx(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 1'b0);
      model_good(b);
   endtask

   task automatic tx_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      send_frame(b, bad_par, bad_stop, 1'b0);
      m_ext = 1'b0;
      m_rel = 1'b0;
      exp_pe++;
   endtask

   task automatic check_events(input string tag);
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
      check({tag, "_perr"}, pe_cnt, exp_pe);
      check({tag, "_tout"}, to_cnt, exp_to);
      obs_q.delete();
      obs_cyc.delete();
      exp_q.delete();
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int off;
      int r;
      logic [7:0] rb;

      reset   = 1'b1;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      wait_cyc(5);
      check("rst_code",     code,        8'h00);
      check("rst_extended", extended,    1'b0);
      check("rst_released", released,    1'b0);
      check("rst_valid",    valid,       1'b0);
      check("rst_perr",     parity_err,  1'b0);
      check("rst_tout",     timeout_err, 1'b0);
      reset = 1'b0;
      wait_cyc(10);

      // plain make code and its latency from the stop-bit clock fall
      tx(8'h1C);
      check("lat_1c", obs_cyc.size() > 0 ? obs_cyc[0] - last_fall : -1, LAT);
      check_events("f1c");
      check("hold_code", code, 8'h1C);

      // extended release, then a bare make with flags cleared
      tx(8'hE0);
      tx(8'hF0);
      tx(8'h75);
      tx(8'h75);
      check_events("ext_rel");

      // bad parity after F0 clears the pending release; then a bad stop bit
      tx(8'hF0);
      tx_bad(8'h1C, 1'b1, 1'b0);
      tx(8'h1C);
      check_events("parity");
      tx_bad(8'h33, 1'b0, 1'b1);
      check_events("stop");

      // partial frame (start + 4 data bits) aborted by the watchdog
      tx(8'hF0);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      wait_cyc(TO + 60);
      off = to_cyc - last_fall;
      check("tout_window", (to_cnt == 1 && off >= TO && off <= TO + LAT + 4), 1'b1);
      m_ext = 1'b0;
      m_rel = 1'b0;
      exp_to++;
      tx(8'h5A);
      check_events("timeout");

      // Pause sequence collapses into one E1 event
      tx(8'hE1); tx(8'h14); tx(8'h77); tx(8'hE1);
      tx(8'hF0); tx(8'h14); tx(8'hF0); tx(8'h77);
      tx(8'h29);
      check_events("pause");

      // short low glitches on every bit's high phase
      send_frame(8'h4B, 1'b0, 1'b0, 1'b1);
      model_good(8'h4B);
      check_events("glitch");

      // reset in the middle of a frame, with a release pending
      tx(8'hE0);
      tx(8'h12);
      check_events("pre_rst");
      tx(8'hF0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      ps2_dat = 1'b1;
      reset   = 1'b1;
      wait_cyc(3);
      check("midrst_code",     code,     8'h00);
      check("midrst_extended", extended, 1'b0);
      check("midrst_valid",    valid,    1'b0);
      reset = 1'b0;
      m_ext  = 1'b0;
      m_rel  = 1'b0;
      m_skip = 0;
      wait_cyc(GAP);
      tx(8'h66);
      check_events("post_rst");

      // randomized byte stream with occasional corrupted frames
      for (int n = 0; n < 24; n++) begin
         r  = int'($urandom_range(0, 9));
         rb = 8'($urandom);
         case (r)
            0:       tx(8'hE0);
            1, 2:    tx(8'hF0);
            3:       tx_bad(rb, 1'b1, 1'b0);
            default: tx(rb);
         endcase
      end
      check_events("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
